// File: rtl/branch_resolve.sv
// ID-stage MIPS branch resolver: evaluates the condition, computes the target, waits for the
// delay slot, then issues a fetch redirect. Optional branch-likely support: BRANCH_LIKELY_EN.
module branch_resolve #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_op,
   input  logic [2:0]       cmp_result,
   input  logic [PC_W-1:0]  br_pc,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [PC_W-1:0]  rs_data,
   input  logic             ds_valid,
   input  logic             flush,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             ds_annul,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {StIdle, StDsWait, StRedirect} state_e;

   localparam logic [3:0] OpBeq  = 4'b0001;
   localparam logic [3:0] OpBne  = 4'b0010;
   localparam logic [3:0] OpBgez = 4'b0011;
   localparam logic [3:0] OpBgtz = 4'b0100;
   localparam logic [3:0] OpBlez = 4'b0101;
   localparam logic [3:0] OpBltz = 4'b0110;
   localparam logic [3:0] OpJ    = 4'b0111;
   localparam logic [3:0] OpJr   = 4'b1000;
`ifdef BRANCH_LIKELY_EN
   localparam logic [3:0] OpBeql = 4'b1001;
   localparam logic [3:0] OpBnel = 4'b1010;
`endif

   state_e           state_q, state_d;
   logic [PC_W-1:0]  target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BRANCH_LIKELY_EN
   logic             annul_q, annul_d;
   logic             likely;
`endif

   logic            op_valid;
   logic            cond_taken;
   logic            accept;
   logic [1:0]      sign_cls;
   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] j_target;
   logic [PC_W-1:0] sel_target;

   assign sign_cls  = cmp_result[1:0];
   assign pc_plus4  = br_pc + PC_W'(4);
   assign br_target = pc_plus4 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
   assign j_target  = {pc_plus4[PC_W-1:28], instr_index, 2'b00};

   always_comb begin
      op_valid   = 1'b1;
      cond_taken = 1'b0;
`ifdef BRANCH_LIKELY_EN
      likely     = 1'b0;
`endif
      // Sign class 11 matches none of the sign cases below, so it is never taken.
      case (br_op)
         OpBeq:   cond_taken = cmp_result[2];
         OpBne:   cond_taken = !cmp_result[2];
         OpBgez:  cond_taken = (sign_cls == 2'b00) || (sign_cls == 2'b01);
         OpBgtz:  cond_taken = (sign_cls == 2'b00);
         OpBlez:  cond_taken = (sign_cls == 2'b01) || (sign_cls == 2'b10);
         OpBltz:  cond_taken = (sign_cls == 2'b10);
         OpJ:     cond_taken = 1'b1;
         OpJr:    cond_taken = 1'b1;
`ifdef BRANCH_LIKELY_EN
         OpBeql: begin
            cond_taken = cmp_result[2];
            likely     = 1'b1;
         end
         OpBnel: begin
            cond_taken = !cmp_result[2];
            likely     = 1'b1;
         end
`endif
         default: op_valid = 1'b0;
      endcase
   end

   always_comb begin
      if (br_op == OpJ) begin
         sel_target = j_target;
      end else if (br_op == OpJr) begin
         sel_target = rs_data;
      end else begin
         sel_target = br_target;
      end
   end

   assign br_ready = resetn && (state_q == StIdle);
   assign accept   = br_valid && br_ready && op_valid && !flush;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      ds_annul = 1'b0;
`ifdef BRANCH_LIKELY_EN
      annul_d  = annul_q;
`endif
      if (flush) begin
         state_d = StIdle;
`ifdef BRANCH_LIKELY_EN
         annul_d = 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (accept && cond_taken) begin
                  target_d = sel_target;
                  state_d  = StDsWait;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
`ifdef BRANCH_LIKELY_EN
                  annul_d = 1'b0;
               end else if (accept && likely) begin
                  annul_d = 1'b1;
                  state_d = StDsWait;
`endif
               end
            end
            StDsWait: begin
               if (ds_valid) begin
`ifdef BRANCH_LIKELY_EN
                  if (annul_q) begin
                     ds_annul = resetn;
                     annul_d  = 1'b0;
                     state_d  = StIdle;
                  end else begin
                     state_d = StRedirect;
                  end
`else
                  state_d = StRedirect;
`endif
               end
            end
            StRedirect: begin
               if (redirect_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         target_q <= '0;
         cnt_q    <= '0;
`ifdef BRANCH_LIKELY_EN
         annul_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
`ifdef BRANCH_LIKELY_EN
         annul_q  <= annul_d;
`endif
      end
   end

   assign redirect_valid = resetn && (state_q == StRedirect);
   assign redirect_pc    = target_q;
   assign taken_cnt      = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; expected redirect targets flow through a scoreboard queue.
// The optional branch-likely checks follow BRANCH_LIKELY_EN.
module tb_branch_resolve;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          br_valid;
   logic          br_ready;
   logic [3:0]    br_op;
   logic [2:0]    cmp_result;
   logic [31:0]   br_pc;
   logic [15:0]   imm16;
   logic [25:0]   instr_index;
   logic [31:0]   rs_data;
   logic          ds_valid;
   logic          flush;
   logic          redirect_valid;
   logic          redirect_ready;
   logic [31:0]   redirect_pc;
   logic          ds_annul;
   logic [CW-1:0] taken_cnt;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;
   logic [31:0] sb[$];
   logic [31:0] cur_exp;

   always #5 clk = ~clk;

   branch_resolve #(.PC_W(32), .CNT_W(CW)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_op          (br_op),
      .cmp_result     (cmp_result),
      .br_pc          (br_pc),
      .imm16          (imm16),
      .instr_index    (instr_index),
      .rs_data        (rs_data),
      .ds_valid       (ds_valid),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .ds_annul       (ds_annul),
      .taken_cnt      (taken_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic present(input logic [3:0] op, input logic [2:0] cmp, input logic [31:0] pc,
                          input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
      br_valid    = 1'b1;
      br_op       = op;
      cmp_result  = cmp;
      br_pc       = pc;
      imm16       = imm;
      instr_index = idx;
      rs_data     = rs;
      tick();
      br_valid    = 1'b0;
      br_op       = 4'b0000;
   endtask

   // Pops the scoreboard when the DUT is seen offering a redirect.
   task automatic take_redirect(input string tag);
      chk({tag, "_valid"}, 32'(redirect_valid), 32'd1);
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         cur_exp = sb.pop_front();
         chk({tag, "_pc"}, redirect_pc, cur_exp);
      end
   endtask

   task automatic finish_redirect(input string tag, input int hold);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(redirect_valid), 32'd1);
         chk({tag, "_hold_pc"}, redirect_pc, cur_exp);
         chk({tag, "_hold_ready"}, 32'(br_ready), 32'd0);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk({tag, "_done_valid"}, 32'(redirect_valid), 32'd0);
      chk({tag, "_done_ready"}, 32'(br_ready), 32'd1);
   endtask

   initial begin
      resetn = 1'b0; br_valid = 1'b0; br_op = 4'b0; cmp_result = 3'b0; br_pc = '0;
      imm16 = '0; instr_index = '0; rs_data = '0; ds_valid = 1'b0; flush = 1'b0;
      redirect_ready = 1'b0;

      tick();
      tick();
      chk("rst_ready", 32'(br_ready), 32'd0);
      chk("rst_rv", 32'(redirect_valid), 32'd0);
      chk("rst_pc", redirect_pc, 32'd0);
      chk("rst_cnt", 32'(taken_cnt), 32'd0);
      chk("rst_annul", 32'(ds_annul), 32'd0);
      resetn = 1'b1;
      tick();
      chk("rel_ready", 32'(br_ready), 32'd1);

      // BEQ taken, delay slot one cycle later, redirect two cycles after accept.
      sb.push_back(32'h0040_0024);
      present(4'b0001, 3'b100, 32'h0040_0010, 16'h0004, 26'h0, 32'h0);
      exp_cnt = sat_inc(exp_cnt);
      chk("beq_dswait_rv", 32'(redirect_valid), 32'd0);
      chk("beq_dswait_ready", 32'(br_ready), 32'd0);
      chk("beq_cnt", 32'(taken_cnt), 32'(exp_cnt));
      ds_valid = 1'b1;
      tick();
      ds_valid = 1'b0;
      take_redirect("beq");
      finish_redirect("beq", 0);

      // BLTZ with rs>0: not taken.
      present(4'b0110, 3'b000, 32'h0000_1000, 16'h0010, 26'h0, 32'h0);
      chk("bltz_ready", 32'(br_ready), 32'd1);
      chk("bltz_rv", 32'(redirect_valid), 32'd0);
      chk("bltz_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // Backward BNE from address 0.
      sb.push_back(32'h0000_0000);
      present(4'b0010, 3'b000, 32'h0000_0000, 16'hFFFF, 26'h0, 32'h0);
      exp_cnt = sat_inc(exp_cnt);
      ds_valid = 1'b1;
      tick();
      ds_valid = 1'b0;
      take_redirect("bne");
      finish_redirect("bne", 0);
      chk("bne_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // J: region bits come from br_pc+4, which crosses into a new 256MB region.
      sb.push_back(32'h2000_048C);
      present(4'b0111, 3'b011, 32'h1FFF_FFFC, 16'h0, 26'h000_0123, 32'h0);
      exp_cnt = sat_inc(exp_cnt);
      ds_valid = 1'b1;
      tick();
      ds_valid = 1'b0;
      take_redirect("j");
      finish_redirect("j", 0);

      // Undefined op is ignored.
      present(4'b1011, 3'b100, 32'h0000_2000, 16'h0001, 26'h0, 32'h0);
      chk("undef_ready", 32'(br_ready), 32'd1);
      chk("undef_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // JR; ds_valid in the accept cycle must not count; redirect_ready held low 3 cycles.
      sb.push_back(32'h8000_0180);
      ds_valid = 1'b1;
      present(4'b1000, 3'b000, 32'h0000_3000, 16'h0, 26'h0, 32'h8000_0180);
      exp_cnt = sat_inc(exp_cnt);
      ds_valid = 1'b0;
      tick();
      chk("jr_ds_ignored", 32'(redirect_valid), 32'd0);
      ds_valid = 1'b1;
      tick();
      ds_valid = 1'b0;
      take_redirect("jr");
      finish_redirect("jr", 3);
      chk("jr_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // BGTZ taken then flushed in DS_WAIT together with ds_valid; flush wins.
      present(4'b0100, 3'b000, 32'h0000_4000, 16'h0008, 26'h0, 32'h0);
      exp_cnt = sat_inc(exp_cnt);
      flush = 1'b1;
      ds_valid = 1'b1;
      tick();
      flush = 1'b0;
      ds_valid = 1'b0;
      chk("flush_ready", 32'(br_ready), 32'd1);
      chk("flush_rv", 32'(redirect_valid), 32'd0);
      tick();
      chk("flush_rv2", 32'(redirect_valid), 32'd0);
      chk("flush_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // No accept during a flush cycle.
      flush = 1'b1;
      present(4'b0001, 3'b100, 32'h0000_5000, 16'h0001, 26'h0, 32'h0);
      flush = 1'b0;
      chk("flush_acc_ready", 32'(br_ready), 32'd1);
      chk("flush_acc_cnt", 32'(taken_cnt), 32'(exp_cnt));

      // Drive the counter into saturation using taken-then-flushed branches.
      for (int i = 0; i < 4; i++) begin
         present(4'b0011, 3'b001, 32'h0000_6000, 16'h0002, 26'h0, 32'h0);
         exp_cnt = sat_inc(exp_cnt);
         flush = 1'b1;
         tick();
         flush = 1'b0;
         chk("sat_cnt", 32'(taken_cnt), 32'(exp_cnt));
      end

      // BLEZ with invalid sign class is not taken.
      present(4'b0101, 3'b011, 32'h0000_7000, 16'h0002, 26'h0, 32'h0);
      chk("blez_inv_ready", 32'(br_ready), 32'd1);

      // Reset while a redirect is pending.
      sb.push_back(32'h0000_8010);
      present(4'b0101, 3'b010, 32'h0000_8000, 16'h0003, 26'h0, 32'h0);
      ds_valid = 1'b1;
      tick();
      ds_valid = 1'b0;
      take_redirect("midrst");
      resetn = 1'b0;
      tick();
      chk("midrst_rv", 32'(redirect_valid), 32'd0);
      chk("midrst_pc", redirect_pc, 32'd0);
      chk("midrst_cnt", 32'(taken_cnt), 32'd0);
      resetn = 1'b1;
      exp_cnt = 0;
      tick();
      chk("midrst_ready", 32'(br_ready), 32'd1);

`ifdef BRANCH_LIKELY_EN
      // BEQL not taken: annul the delay slot, no redirect.
      present(4'b1001, 3'b000, 32'h0000_9000, 16'h0004, 26'h0, 32'h0);
      chk("beql_ready", 32'(br_ready), 32'd0);
      chk("beql_pre_annul", 32'(ds_annul), 32'd0);
      ds_valid = 1'b1;
      #1;
      chk("beql_annul", 32'(ds_annul), 32'd1);
      tick();
      ds_valid = 1'b0;
      #1;
      chk("beql_annul_off", 32'(ds_annul), 32'd0);
      chk("beql_rv", 32'(redirect_valid), 32'd0);
      chk("beql_idle", 32'(br_ready), 32'd1);
      chk("beql_cnt", 32'(taken_cnt), 32'(exp_cnt));
`else
      // Without the option the branch-likely encodings behave as none.
      present(4'b1001, 3'b000, 32'h0000_9000, 16'h0004, 26'h0, 32'h0);
      chk("beql_none_ready", 32'(br_ready), 32'd1);
      ds_valid = 1'b1;
      #1;
      chk("beql_none_annul", 32'(ds_annul), 32'd0);
      tick();
      ds_valid = 1'b0;
      chk("beql_none_rv", 32'(redirect_valid), 32'd0);
      chk("beql_none_cnt", 32'(taken_cnt), 32'(exp_cnt));
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolves conditional and unconditional MIPS branches in the ID stage.
- Consumes the 3-bit result of the operand comparator (equality plus sign class of rs) together with the decoded branch op.
- Computes the branch target and tracks the architectural delay slot.
- Issues a PC redirect to fetch, using a valid/ready handshake, only after the delay slot has been issued.

Parameters:
- PC_W, 32, width of PC, offsets and targets.
- CNT_W, 16, width of the taken-branch statistics counter (saturating).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous active-low reset.
- br_valid  in  1  a decoded branch/jump is presented.
- br_ready  out  1  block can accept a branch.
- br_op  in  4  0000 none, 0001 BEQ, 0010 BNE, 0011 BGEZ, 0100 BGTZ, 0101 BLEZ, 0110 BLTZ, 0111 J/JAL, 1000 JR/JALR.
- cmp_result  in  3  [2] = rs==rt; [1:0] = 00 rs>0, 01 rs==0, 10 rs<0, 11 invalid.
- br_pc  in  PC_W  PC of the branch instruction.
- imm16  in  16  branch offset field.
- instr_index  in  26  J-type target field.
- rs_data  in  PC_W  register target for JR.
- ds_valid  in  1  the delay-slot instruction is accepted into ID this cycle.
- flush  in  1  exception/ERET flush.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  PC_W  redirect target.
- ds_annul  out  1  kill the delay-slot instruction (optional feature only).
- taken_cnt  out  CNT_W  number of taken branches/jumps.

Behaviour:
- Reset values when resetn=0 at a clock edge: state=IDLE, br_ready=0 during the reset cycle, redirect_valid=0, redirect_pc=0, ds_annul=0, taken_cnt=0.
- States: IDLE, DS_WAIT, REDIRECT.
- br_ready is 1 only in IDLE. Accept occurs when br_valid & br_ready & br_op!=0000.
- Taken rules:
  - BEQ: cmp[2]=1.
  - BNE: cmp[2]=0.
  - BGEZ: cmp[1:0] is 00 or 01.
  - BGTZ: cmp[1:0]=00.
  - BLEZ: cmp[1:0] is 01 or 10.
  - BLTZ: cmp[1:0]=10.
  - J and JR: always taken.
  - cmp[1:0]=11 means not taken for all sign-based ops.
  - Any undefined br_op is treated as none.
- Target computation (all arithmetic modulo 2^PC_W; wrap-around is allowed and not flagged):
  - Branches: br_pc+4 + (sign-extended imm16 << 2).
  - J: {(br_pc+4)[31:28], instr_index, 2'b00}.
  - JR: rs_data, used unaligned as-is (fetch raises AdEL).
- Accept, taken: latch the target, increment taken_cnt (saturating at all ones), go to DS_WAIT.
- Accept, not taken: stay in IDLE; no redirect is issued.
- DS_WAIT: on the first cycle with ds_valid=1, go to REDIRECT. ds_valid in the accept cycle itself is ignored.
- REDIRECT:
  - redirect_valid=1 and redirect_pc holds stable until redirect_ready=1.
  - The handshake cycle returns to IDLE. br_ready rises the following cycle.
- Minimum latency from accept to redirect_valid is 2 cycles (accept, DS_WAIT with ds_valid, REDIRECT).
- flush has the highest priority:
  - Any state goes to IDLE next cycle and redirect_valid drops.
  - No accept happens in a flush cycle.
  - taken_cnt is not rolled back.
- resetn asserted mid-operation: all state is lost and outputs return to their reset values.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- When defined:
  - br_op 1001 = BEQL and 1010 = BNEL.
  - If the branch-likely is taken, behaviour is as for BEQ/BNE.
  - If not taken, the block enters DS_WAIT with an annul flag. On ds_valid it pulses ds_annul=1 for exactly that cycle and returns to IDLE with no redirect.
- When undefined: 1001 and 1010 are treated as none, and ds_annul is tied to 0.

Test Plan:
- Reset with resetn=0 for 2 cycles -> redirect_valid=0, taken_cnt=0, br_ready=1 on the first cycle after release.
- BEQ with br_pc=0x00400010, imm16=0x0004, cmp=3'b100, ds_valid one cycle later, redirect_ready=1 -> redirect_pc=0x00400024 asserted 2 cycles after accept; taken_cnt=1.
- BLTZ with cmp=3'b000 -> no redirect, state stays IDLE, br_ready stays 1, taken_cnt unchanged.
- Backward BNE with br_pc=0x00000000, imm16=0xFFFF, cmp=3'b000 -> redirect_pc=0x00000000 (0+4-4); the result wraps correctly.
- JR with rs_data=0x8000_0180, redirect_ready held low for 3 cycles -> redirect_valid and redirect_pc stay stable for all 3 cycles; br_ready=0 until the cycle after the handshake.
- Taken BGTZ, then flush in DS_WAIT -> IDLE next cycle, no redirect_valid ever seen. With BRANCH_LIKELY_EN: BEQL with cmp=3'b000 -> ds_annul=1 for exactly the ds_valid cycle and no redirect.
